ascon_round_sched: RTL and testbench
====================================

Name: ascon_round_sched

Overview:
Sequencer for the serialized, masked Ascon permutation datapath (d+1 shares, PAR bits per cycle).
- Runs a requested number of rounds (p^a = 12, p^b = 6/8).
- Issues per-round phases in order: constant addition, sliced masked S-box, pipeline drain, linear layer.
- Throttles S-box slices on the availability of fresh randomness from the PRNG (valid/ready).
- Sits between the mode FSM (start/done) and the permutation datapath plus PRNG.

Parameters:
- PAR, default ascon_params::PAR (22): S-box slice width in bits.
- SBOX_LAT, default 1: register stages in the masked S-box, 0..3. Sets the number of drain cycles after the last slice.
- MAX_ROUNDS, default 12: full permutation round count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  start request. Sampled only in IDLE.
- rounds_i  in  4  round count for this run, sampled with start_i.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse when a run completes.
- rnd_valid_i  in  1  PRNG has RAND_WIDTH fresh random bits.
- rnd_ready_o  out  1  scheduler consumes randomness this cycle if valid.
- const_add_o  out  1  datapath XORs const_o into x2 this cycle.
- const_o  out  8  round constant.
- sbox_en_o  out  1  datapath processes slice slice_idx_o this cycle.
- slice_idx_o  out  SLICE_IDX_W  current slice, 0..NUM_SLICES-1.
- slice_last_o  out  1  current slice is the final, narrower slice (SHIFT_PAR_LAST bits).
- lin_en_o  out  1  datapath applies the linear diffusion layer this cycle.
- round_idx_o  out  4  index of the current round within the 12-round schedule.

Behaviour:
- Reset: a single sync rst, active-high, on clk. All outputs are 0, state is IDLE, counters are 0.
- Reset mid-run aborts immediately: outputs are 0 from the next cycle and no done_o is issued.
- NUM_SLICES = ceil(64/PAR) = 3 for PAR=22.
- FSM states: IDLE, CONST, SBOX, DRAIN, LINEAR.
- IDLE:
  - start_i=1 with rounds_i in 1..12 latches the start index ri = 12-rounds_i and moves to CONST.
  - rounds_i > 12 is clamped to 12.
  - rounds_i = 0: done_o pulses the next cycle, busy_o stays 0.
  - start_i while busy_o=1 is ignored.
- CONST (1 cycle):
  - const_add_o=1.
  - const_o = ROUND_CONST[ri] = 0xF0 - ri*0x0F, giving F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - Next state SBOX with slice=0.
- SBOX:
  - rnd_ready_o=1; sbox_en_o = rnd_valid_i.
  - On handshake the slice increments. A handshake on slice NUM_SLICES-1 moves to DRAIN, or to LINEAR if SBOX_LAT=0.
  - No handshake means slice_idx_o holds and sbox_en_o=0 (stall).
- DRAIN: SBOX_LAT cycles, all enables 0, then LINEAR.
- LINEAR (1 cycle):
  - lin_en_o=1.
  - If ri=11, go to IDLE and assert done_o, registered, in the next cycle.
  - Otherwise ri++ and go to CONST.
- Output rules:
  - busy_o=1 in every state except IDLE.
  - round_idx_o = ri while busy_o=1, else 0.
  - rnd_ready_o is 0 outside SBOX; randomness is never consumed in other states.
  - slice_last_o = busy_o and (slice == NUM_SLICES-1).
- Latency with rnd_valid_i held at 1: busy cycles = rounds*(2+NUM_SLICES+SBOX_LAT), which is 72 for 12 rounds at SBOX_LAT=1.
  - start is sampled at edge 0, CONST occurs in cycle 1, and done_o pulses in cycle 73.
- All enables are mutually exclusive.

Optional Feature:
- Macro ASCON_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o (16 bits).
  - Counts SBOX cycles with rnd_valid_i=0; saturates at 0xFFFF.
  - Cleared on an accepted start and on rst; holds after done.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Add to the ascon_params package:
  - MAX_ROUNDS.
  - NUM_SLICES = (64+PAR-1)/PAR.
  - SLICE_IDX_W = max(1, $clog2(NUM_SLICES)).
  - ROUND_CONST[0:11] byte array.
  - sched_state_e enum {IDLE, CONST, SBOX, DRAIN, LINEAR}.
- One sub-module, ascon_rc_gen: combinational ri -> const_o lookup, reusable by the unmasked path.

Test Plan:
1. rounds_i=12, rnd_valid_i=1, SBOX_LAT=1 -> busy_o=1 for 72 cycles; const_o sequence F0..4B; 36 sbox_en_o and 12 lin_en_o pulses; a single done_o in cycle 73.
2. rounds_i=6 -> const_o = 96,87,78,69,5A,4B; round_idx_o runs 6..11; 36 busy cycles.
3. rnd_valid_i low for 2 cycles during slice 1 of round 0 -> slice_idx_o holds 1 and sbox_en_o=0 for those cycles; done is delayed by 2 cycles; stall_cnt_o=2 when the macro is defined.
4. start_i pulsed in cycle 10 of a run -> ignored, run timing unchanged; separately, rounds_i=0 -> done_o the next cycle and busy_o never high.
5. rst asserted in SBOX of round 3 -> all outputs 0 the next cycle, no done_o; a subsequent rounds_i=8 run starts at const B4 and completes normally.
6. SBOX_LAT=0 build -> LINEAR immediately follows the last slice; 12 rounds take 60 busy cycles; slice_last_o is high only when slice_idx_o=2.

Source files
------------

// File: rtl/ascon_params.sv
`default_nettype none
// ============================================================================
// Module      : ascon_params (package)
// Description : Shared parameters and types for the serialized, masked Ascon
//               permutation datapath and its round scheduler.
//               - PAR          : S-box slice width in bits
//               - MAX_ROUNDS   : full permutation round count (p^a)
//               - NUM_SLICES   : slices needed to cover one 64-bit lane
//               - SLICE_IDX_W  : width of a slice index (at least 1)
//               - ROUND_CONST  : round constants for the 12-round schedule
//               - sched_state_e: round scheduler states
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_params;

    localparam int PAR         = 22;
    localparam int MAX_ROUNDS  = 12;
    localparam int NUM_SLICES  = (64 + PAR - 1) / PAR;
    localparam int SLICE_IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    // Constant for round index ri is 0xF0 - ri*0x0F.
    localparam logic [7:0] ROUND_CONST [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONST  = 3'd1,
        SBOX   = 3'd2,
        DRAIN  = 3'd3,
        LINEAR = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/ascon_rc_gen.sv
`default_nettype none
// ============================================================================
// Module      : ascon_rc_gen
// Description : Combinational round-constant lookup. Maps a round index
//               within the 12-round schedule to its 8-bit constant; indices
//               outside the schedule return 0. Shared with the unmasked path.
// Ports       : i_ri [3:0]  round index
//               o_rc [7:0]  round constant
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_rc_gen
    import ascon_params::*;
(
    input  logic [3:0] i_ri,
    output logic [7:0] o_rc
);

    always_comb begin
        o_rc = 8'h00;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            if (i_ri == 4'(i)) begin
                o_rc = ROUND_CONST[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascon_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : ascon_round_sched
// Description : Round sequencer for the serialized, masked Ascon permutation.
//               Each round runs CONST (1 cycle), SBOX (NUM_SLICES slices,
//               each gated by a PRNG handshake), DRAIN (SBOX_LAT cycles) and
//               LINEAR (1 cycle). Runs start at ri = MAX_ROUNDS - rounds_i
//               and end after ri = MAX_ROUNDS-1 with a one-cycle done_o.
// Ports       : clk, rst           clock, synchronous active-high reset
//               start_i, rounds_i  run request and round count (IDLE only)
//               busy_o, done_o     run in progress / completion pulse
//               rnd_valid_i        PRNG has fresh randomness
//               rnd_ready_o        randomness consumed this cycle if valid
//               const_add_o/const_o  constant-addition enable and constant
//               sbox_en_o, slice_idx_o, slice_last_o  S-box slice control
//               lin_en_o           linear-layer enable
//               round_idx_o        current round index (0 when idle)
//               stall_cnt_o        SBOX cycles without randomness
//                                  (only with ASCON_SCHED_STALL_CNT_EN)
// Options     : `define ASCON_SCHED_STALL_CNT_EN adds the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_round_sched #(
    parameter  int PAR         = ascon_params::PAR,
    parameter  int SBOX_LAT    = 1,
    parameter  int MAX_ROUNDS  = ascon_params::MAX_ROUNDS,
    localparam int NUM_SLICES  = (64 + PAR - 1) / PAR,
    localparam int SLICE_IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [3:0]             rounds_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   rnd_valid_i,
    output logic                   rnd_ready_o,
    output logic                   const_add_o,
    output logic [7:0]             const_o,
    output logic                   sbox_en_o,
    output logic [SLICE_IDX_W-1:0] slice_idx_o,
    output logic                   slice_last_o,
    output logic                   lin_en_o,
`ifdef ASCON_SCHED_STALL_CNT_EN
    output logic [15:0]            stall_cnt_o,
`endif
    output logic [3:0]             round_idx_o
);

    typedef ascon_params::sched_state_e state_t;

    localparam logic [3:0]             c_max_rounds = 4'(MAX_ROUNDS);
    localparam logic [3:0]             c_last_ri    = 4'(MAX_ROUNDS - 1);
    localparam logic [SLICE_IDX_W-1:0] c_last_slice = SLICE_IDX_W'(NUM_SLICES - 1);
    localparam logic [1:0]             c_drain_last = (SBOX_LAT > 0) ? 2'(SBOX_LAT - 1) : 2'd0;

    state_t                 r_state;
    logic [3:0]             r_ri;
    logic [SLICE_IDX_W-1:0] r_slice;
    logic [1:0]             r_drain;
    logic                   r_done;

    logic [3:0]             w_rounds;
    logic [7:0]             w_rc;
    logic                   w_busy;

    // Oversized round requests run the full permutation.
    assign w_rounds = (rounds_i > c_max_rounds) ? c_max_rounds : rounds_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ascon_params::IDLE;
            r_ri    <= 4'd0;
            r_slice <= '0;
            r_drain <= 2'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ascon_params::IDLE: begin
                    if (start_i) begin
                        if (w_rounds == 4'd0) begin
                            // Zero-round run completes without going busy.
                            r_done <= 1'b1;
                        end else begin
                            r_ri    <= c_max_rounds - w_rounds;
                            r_state <= ascon_params::CONST;
                        end
                    end
                end
                ascon_params::CONST: begin
                    r_slice <= '0;
                    r_state <= ascon_params::SBOX;
                end
                ascon_params::SBOX: begin
                    if (rnd_valid_i) begin
                        if (r_slice == c_last_slice) begin
                            // Wrap so slice_last_o only flags the real last slice.
                            r_slice <= '0;
                            r_drain <= 2'd0;
                            if (SBOX_LAT == 0) begin
                                r_state <= ascon_params::LINEAR;
                            end else begin
                                r_state <= ascon_params::DRAIN;
                            end
                        end else begin
                            r_slice <= r_slice + 1'b1;
                        end
                    end
                end
                ascon_params::DRAIN: begin
                    if (r_drain == c_drain_last) begin
                        r_state <= ascon_params::LINEAR;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                ascon_params::LINEAR: begin
                    if (r_ri == c_last_ri) begin
                        r_ri    <= 4'd0;
                        r_done  <= 1'b1;
                        r_state <= ascon_params::IDLE;
                    end else begin
                        r_ri    <= r_ri + 4'd1;
                        r_state <= ascon_params::CONST;
                    end
                end
                default: r_state <= ascon_params::IDLE;
            endcase
        end
    end

`ifdef ASCON_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (r_state == ascon_params::IDLE && start_i) begin
            r_stall_cnt <= 16'd0;
        end else if (r_state == ascon_params::SBOX && !rnd_valid_i
                     && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    ascon_rc_gen u_rc_gen (
        .i_ri (r_ri),
        .o_rc (w_rc)
    );

    assign w_busy       = (r_state != ascon_params::IDLE);
    assign busy_o       = w_busy;
    assign done_o       = r_done;
    assign rnd_ready_o  = (r_state == ascon_params::SBOX);
    assign sbox_en_o    = (r_state == ascon_params::SBOX) && rnd_valid_i;
    assign const_add_o  = (r_state == ascon_params::CONST);
    assign const_o      = (r_state == ascon_params::CONST) ? w_rc : 8'h00;
    assign lin_en_o     = (r_state == ascon_params::LINEAR);
    assign slice_idx_o  = r_slice;
    assign slice_last_o = w_busy && (r_slice == c_last_slice);
    assign round_idx_o  = w_busy ? r_ri : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_ascon_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_round_sched
// Description : Self-checking bench for ascon_round_sched. A scoreboard of
//               expected (round index, constant) pairs is filled when a run
//               is launched and drained on each const_add_o. A second
//               instance with SBOX_LAT=0 runs alongside the default one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_round_sched;

    typedef struct packed {
        logic [3:0] ri;
        logic [7:0] rc;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] rounds_i = 4'd0;
    logic       rnd_valid_i = 1'b1;

    logic       busy_o, done_o, rnd_ready_o, const_add_o, sbox_en_o, slice_last_o, lin_en_o;
    logic [7:0] const_o;
    logic [1:0] slice_idx_o;
    logic [3:0] round_idx_o;
    logic       b_busy, b_done, b_ready, b_cadd, b_sbox, b_last, b_lin;
    logic [7:0] b_const;
    logic [1:0] b_slice;
    logic [3:0] b_ridx;
`ifdef ASCON_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_o, b_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_cnt, sbox_cnt, lin_cnt, done_cnt, done_cyc;
    int b_busy_cnt, b_done_cyc;
    logic prev_last_hs = 1'b0;
    logic b_prev_last_hs = 1'b0;
    sb_t exp_q[$];
    sb_t e_mon;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_round_sched #(.SBOX_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .rounds_i(rounds_i),
        .busy_o(busy_o), .done_o(done_o), .rnd_valid_i(rnd_valid_i),
        .rnd_ready_o(rnd_ready_o), .const_add_o(const_add_o), .const_o(const_o),
        .sbox_en_o(sbox_en_o), .slice_idx_o(slice_idx_o), .slice_last_o(slice_last_o),
        .lin_en_o(lin_en_o),
`ifdef ASCON_SCHED_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .round_idx_o(round_idx_o)
    );

    ascon_round_sched #(.SBOX_LAT(0)) u_dut_lat0 (
        .clk(clk), .rst(rst), .start_i(start_i), .rounds_i(rounds_i),
        .busy_o(b_busy), .done_o(b_done), .rnd_valid_i(rnd_valid_i),
        .rnd_ready_o(b_ready), .const_add_o(b_cadd), .const_o(b_const),
        .sbox_en_o(b_sbox), .slice_idx_o(b_slice), .slice_last_o(b_last),
        .lin_en_o(b_lin),
`ifdef ASCON_SCHED_STALL_CNT_EN
        .stall_cnt_o(b_stall),
`endif
        .round_idx_o(b_ridx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: scoreboard pops and structural invariants.
    always @(negedge clk) begin
        if (busy_o === 1'b1) busy_cnt++;
        if (sbox_en_o === 1'b1) sbox_cnt++;
        if (lin_en_o === 1'b1) lin_cnt++;
        if (done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (b_busy === 1'b1) b_busy_cnt++;
        if (b_done === 1'b1) b_done_cyc = cyc;
        if (const_add_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("const_spurious", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("const_o", 32'(const_o), 32'(e_mon.rc));
                check("round_idx", 32'(round_idx_o), 32'(e_mon.ri));
            end
        end
        check("excl", 32'($countones({const_add_o, sbox_en_o, lin_en_o}) <= 1), 32'd1);
        check("ready_outside_sbox", 32'(rnd_ready_o & (const_add_o | lin_en_o | ~busy_o)), 32'd0);
        check("sbox_en", 32'(sbox_en_o), 32'(rnd_ready_o & rnd_valid_i));
        check("slice_last", 32'(slice_last_o), 32'(busy_o && slice_idx_o == 2'd2));
        if (prev_last_hs) check("drain_idle", 32'(lin_en_o | sbox_en_o | const_add_o), 32'd0);
        prev_last_hs = sbox_en_o & slice_last_o;
        check("b_excl", 32'($countones({b_cadd, b_sbox, b_lin}) <= 1), 32'd1);
        check("b_slice_last", 32'(b_last), 32'(b_busy && b_slice == 2'd2));
        if (b_prev_last_hs) check("b_lin_follows", 32'(b_lin), 32'd1);
        b_prev_last_hs = b_sbox & b_last;
    end

    int t0;

    // Push expectations, clear counters, pulse start; returns in cycle 1.
    task automatic launch(input int rounds);
        int r;
        sb_t e;
        r = (rounds > 12) ? 12 : rounds;
        for (int k = 12 - r; k < 12; k++) begin
            e.ri = 4'(k);
            e.rc = 8'(240 - 15 * k);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        busy_cnt = 0; sbox_cnt = 0; lin_cnt = 0; done_cnt = 0; done_cyc = -1;
        b_busy_cnt = 0; b_done_cyc = -1;
        start_i = 1'b1;
        rounds_i = 4'(rounds);
        @(posedge clk); #1;
        start_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic run(input int rounds, input bit stall, input bit poke, input bit chk_b,
                       input int exp_busy, input int exp_done, input string tag);
        int r;
        int waited;
        r = (rounds > 12) ? 12 : rounds;
        launch(rounds);
        if (stall) begin
            repeat (2) @(posedge clk);
            #1 rnd_valid_i = 1'b0;
            @(negedge clk); #1;
            check({tag, "_stall_slice"}, 32'(slice_idx_o), 32'd1);
            check({tag, "_stall_en"}, 32'(sbox_en_o), 32'd0);
            @(posedge clk); #1;
            @(negedge clk); #1;
            check({tag, "_stall_slice2"}, 32'(slice_idx_o), 32'd1);
            @(posedge clk); #1 rnd_valid_i = 1'b1;
        end
        if (poke) begin
            repeat (9) @(posedge clk);
            #1 start_i = 1'b1; rounds_i = 4'd5;
            @(posedge clk); #1 start_i = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 400) begin
            @(negedge clk); #1;
            waited++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done_cycle"}, 32'(done_cyc - t0 + 1), 32'(exp_done));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_sbox_count"}, 32'(sbox_cnt), 32'(3 * r));
        check({tag, "_lin_count"}, 32'(lin_cnt), 32'(r));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        if (chk_b) begin
            check({tag, "_lat0_busy"}, 32'(b_busy_cnt), 32'd60);
            check({tag, "_lat0_done_cycle"}, 32'(b_done_cyc - t0 + 1), 32'd61);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_outputs", 32'({done_o, rnd_ready_o, const_add_o, sbox_en_o, lin_en_o, slice_last_o}), 32'd0);
        check("rst_vectors", 32'({const_o, slice_idx_o, round_idx_o}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run(12, 1'b0, 1'b0, 1'b1, 72, 73, "full12");
        run(6,  1'b0, 1'b0, 1'b0, 36, 37, "pb6");
        run(12, 1'b1, 1'b0, 1'b0, 74, 75, "stall");
`ifdef ASCON_SCHED_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt_o), 32'd2);
`endif
        run(12, 1'b0, 1'b1, 1'b0, 72, 73, "start_busy");
        run(0,  1'b0, 1'b0, 1'b0, 0, 1, "zero");
        run(15, 1'b0, 1'b0, 1'b0, 72, 73, "clamp");

        // Reset in SBOX of round 3 (cycle 20).
        launch(12);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("pre_rst_sbox", 32'(rnd_ready_o), 32'd1);
        check("pre_rst_round", 32'(round_idx_o), 32'd3);
        @(posedge clk); #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_outputs", 32'({done_o, rnd_ready_o, const_add_o, sbox_en_o, lin_en_o, slice_last_o}), 32'd0);
        check("abort_vectors", 32'({const_o, slice_idx_o, round_idx_o}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("abort_sb_left", 32'(exp_q.size()), 32'd8);
        exp_q.delete();
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_busy_cycles", 32'(busy_cnt), 32'd20);
        run(8, 1'b0, 1'b0, 1'b0, 48, 49, "after_rst8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
